// File: rtl/fft_sdf_r2_stage.sv
// Radix-2 single-path delay-feedback butterfly stage with a DEPTH-deep difference line,
// optional halving or saturation, valid-gated input and an explicit drain of stored differences.
`timescale 1ns/1ps
module fft_sdf_r2_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int SCALE = 1,
    parameter int CNT_W = $clog2(2*DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Input_Re,
    input  logic [WIDTH-1:0] Input_Im,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic             Flush,
    output logic [WIDTH-1:0] Output_Re,
    output logic [WIDTH-1:0] Output_Im,
    output logic             Out_Valid
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {ST_RUN, ST_DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               pending_reg, pending_next;
    logic [PTR_W-1:0]   ptr_reg, ptr_next;
    logic [2*WIDTH-1:0] out_reg, out_next;
    logic               valid_reg, valid_next;

    // Complex samples are packed {im, re}; the line is a circular buffer that is always full,
    // so the head being read is also the slot being overwritten.
    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [2*WIDTH-1:0] head, x_pk, sum_pk, dif_pk, push_val;
    logic               accept, shift, phase_b;

    function automatic logic [WIDTH-1:0] fix(input logic [WIDTH:0] v);
        if (SCALE != 0)
            fix = v[WIDTH:1];
        else if (v[WIDTH] != v[WIDTH-1])
            fix = v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        else
            fix = v[WIDTH-1:0];
    endfunction

    assign head     = mem[ptr_reg];
    assign x_pk     = {Input_Im, Input_Re};
    assign In_Ready = (state_reg == ST_RUN);
    assign accept   = In_Valid & In_Ready;
    assign phase_b  = (cnt_reg >= CNT_W'(DEPTH));

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_comp
            logic [WIDTH:0] a_ext, b_ext, sum_w, dif_w;
            assign a_ext = {head[gi*WIDTH+WIDTH-1], head[gi*WIDTH +: WIDTH]};
            assign b_ext = {x_pk[gi*WIDTH+WIDTH-1], x_pk[gi*WIDTH +: WIDTH]};
            assign sum_w = a_ext + b_ext;
            assign dif_w = a_ext - b_ext;
            assign sum_pk[gi*WIDTH +: WIDTH] = fix(sum_w);
            assign dif_pk[gi*WIDTH +: WIDTH] = fix(dif_w);
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        pending_next = pending_reg;
        ptr_next     = ptr_reg;
        out_next     = out_reg;
        valid_next   = 1'b0;
        shift        = 1'b0;
        push_val     = x_pk;
        case (state_reg)
            ST_RUN: begin
                if (accept) begin
                    shift    = 1'b1;
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(2*DEPTH-1))
                        pending_next = 1'b1;
                    if (phase_b) begin
                        push_val   = dif_pk;
                        out_next   = sum_pk;
                        valid_next = 1'b1;
                    end else begin
                        out_next   = head;
                        valid_next = pending_reg;
                    end
                end else if (Flush && cnt_reg == '0 && pending_reg) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // cnt sits at 0 between frames, so it doubles as the drain step counter
                shift      = 1'b1;
                push_val   = '0;
                out_next   = head;
                valid_next = 1'b1;
                cnt_next   = cnt_reg + CNT_W'(1);
                if (cnt_reg == CNT_W'(DEPTH-1)) begin
                    cnt_next     = '0;
                    pending_next = 1'b0;
                    state_next   = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
        if (shift)
            ptr_next = (ptr_reg == PTR_W'(DEPTH-1)) ? '0 : ptr_reg + PTR_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_RUN;
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
            ptr_reg     <= '0;
            out_reg     <= '0;
            valid_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            pending_reg <= pending_next;
            ptr_reg     <= ptr_next;
            out_reg     <= out_next;
            valid_reg   <= valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (shift)
            mem[ptr_reg] <= push_val;
    end

    assign Output_Re = out_reg[WIDTH-1:0];
    assign Output_Im = out_reg[2*WIDTH-1:WIDTH];
    assign Out_Valid = valid_reg;
endmodule
